// File: rtl/sll_arb_pkg.sv
// Shared constants and types for the round-robin arbiter in front of the shared 64-bit left shifter.
package sll_arb_pkg;

  localparam int SHIFT_W  = 6;
  localparam int DATA_W   = 64;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [DATA_W-1:0]   data;
  } rsp_entry_t;

  // Index reached k steps upward from p, wrapping at n.
  function automatic int rr_index(input int p, input int k, input int n);
    return (p + k) % n;
  endfunction

endpackage

// File: rtl/sll_64b.sv
// 64-bit logical left shifter with optional output register.
// done_o marks the cycle in which data_o holds the result of an init_i request.
module sll_64b
  import sll_arb_pkg::*;
#(
  parameter logic OUT_REG = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               done_o,
  output logic [DATA_W-1:0]  data_o
);

  logic [DATA_W-1:0] w_shifted;
  assign w_shifted = data_i << shift_i;

  generate
    if (OUT_REG) begin : g_reg
      logic              r_done;
      logic [DATA_W-1:0] r_data;

      // Result register; holds zero while idle.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_done <= 1'b0;
          r_data <= '0;
        end else begin
          r_done <= init_i;
          r_data <= init_i ? w_shifted : '0;
        end
      end

      assign done_o = r_done;
      assign data_o = r_data;
    end else begin : g_comb
      logic w_unused_clk;
      assign w_unused_clk = clk_i ^ rst_ni;
      assign done_o       = init_i;
      assign data_o       = w_shifted;
    end
  endgenerate

endmodule

// File: rtl/sll_64b_arb.sv
// Round-robin arbiter sharing one sll_64b among N_REQ requesters; results come back
// in issue order through a credit-protected circular response FIFO.
module sll_64b_arb
  import sll_arb_pkg::*;
#(
  parameter int   N_REQ      = 4,
  parameter logic OUT_REG    = 1'b1,
  parameter int   FIFO_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ-1:0][SHIFT_W-1:0]   req_shift_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]    req_data_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0]        rsp_id_o,
  output logic [DATA_W-1:0]               rsp_data_o
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FP_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [FP_W-1:0]  LAST_C  = FP_W'(FIFO_DEPTH - 1);

  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_fcnt;
  logic [FP_W-1:0]    r_wr;
  logic [FP_W-1:0]    r_rd;
  rsp_entry_t         r_mem [FIFO_DEPTH];

  logic               w_found;
  logic               w_hit;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_pop;
  logic               w_credit;
  logic               w_issue;
  logic               w_rst_n;
  logic               w_done;
  logic [DATA_W-1:0]  w_sh_data;
  logic [ID_W-1:0]    w_tag_out;
  logic               w_unused_id;

  // First valid requester at or above r_ptr, searching upward with wrap.
  always_comb begin
    w_found   = 1'b0;
    w_hit     = 1'b0;
    w_idx     = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx     = ID_W'(rr_index(int'(r_ptr), k, N_REQ));
      w_hit     = !w_found && req_valid_i[w_idx];
      w_gnt_idx = w_hit ? w_idx : w_gnt_idx;
      w_found   = w_found | w_hit;
    end
  end

  assign rsp_valid_o = (r_fcnt != '0);
  assign w_pop       = rsp_valid_o & rsp_ready_i;
  // A pop in the same cycle frees the slot a full credit count would otherwise block.
  assign w_credit    = (r_cnt < DEPTH_C) | w_pop;
  assign w_issue     = w_found & w_credit & ~rst_i;
  assign req_ready_o = w_issue ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign w_rst_n     = ~rst_i;

  sll_64b #(
    .OUT_REG (OUT_REG)
  ) u_sll (
    .clk_i   (clk_i),
    .rst_ni  (w_rst_n),
    .init_i  (w_issue),
    .shift_i (w_issue ? req_shift_i[w_gnt_idx] : '0),
    .data_i  (w_issue ? req_data_i[w_gnt_idx] : '0),
    .done_o  (w_done),
    .data_o  (w_sh_data)
  );

  generate
    if (OUT_REG) begin : g_tag_reg
      logic [ID_W-1:0] r_tag;

      // One-stage tag pipe tracking the shifter's output register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_tag <= '0;
        end else begin
          r_tag <= w_issue ? w_gnt_idx : '0;
        end
      end

      assign w_tag_out = r_tag;
    end else begin : g_tag_comb
      assign w_tag_out = w_gnt_idx;
    end
  endgenerate

  // Pointer, credit and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_fcnt <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
    end else begin
      r_ptr  <= w_issue ? ID_W'(rr_index(int'(w_gnt_idx), 1, N_REQ)) : r_ptr;
      r_cnt  <= r_cnt + CNT_W'(w_issue) - CNT_W'(w_pop);
      r_fcnt <= r_fcnt + CNT_W'(w_done) - CNT_W'(w_pop);
      r_wr   <= w_done ? ((r_wr == LAST_C) ? '0 : r_wr + FP_W'(1)) : r_wr;
      r_rd   <= w_pop  ? ((r_rd == LAST_C) ? '0 : r_rd + FP_W'(1)) : r_rd;
    end
  end

  // Response storage; cleared so the head reads as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_done) begin
      r_mem[r_wr] <= '{id: ID_MAX_W'(w_tag_out), data: w_sh_data};
    end else begin
      r_mem[r_wr] <= r_mem[r_wr];
    end
  end

  assign rsp_id_o    = r_mem[r_rd].id[ID_W-1:0];
  assign rsp_data_o  = r_mem[r_rd].data;
  assign w_unused_id = ^r_mem[r_rd].id;

endmodule

// File: tb/tb_sll_64b_arb.sv
// Directed bench for sll_64b_arb: one instance with OUT_REG=1 and one with OUT_REG=0 on shared stimulus.
module tb_sll_64b_arb;
  import sll_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0][5:0]   req_shift;
  logic [3:0][63:0]  req_data;
  logic              rsp_ready;

  logic [3:0]        ready1, ready0;
  logic              rv1, rv0;
  logic [1:0]        rid1, rid0;
  logic [63:0]       rd1, rd0;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_oh;

  always #5 clk = ~clk;

  sll_64b_arb #(.N_REQ(4), .OUT_REG(1'b1), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_shift_i(req_shift), .req_data_i(req_data), .rsp_valid_o(rv1),
    .rsp_ready_i(rsp_ready), .rsp_id_o(rid1), .rsp_data_o(rd1));

  sll_64b_arb #(.N_REQ(4), .OUT_REG(1'b0), .FIFO_DEPTH(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready0),
    .req_shift_i(req_shift), .req_data_i(req_data), .rsp_valid_o(rv0),
    .rsp_ready_i(rsp_ready), .rsp_id_o(rid0), .rsp_data_o(rd0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_all(input logic [5:0] s, input logic [63:0] d);
    for (int i = 0; i < 4; i++) begin
      req_shift[i] = s;
      req_data[i]  = d;
    end
  endtask

  task automatic set_ramp();
    req_data[0] = 64'h0000_0000_0000_1111;
    req_data[1] = 64'h0000_0000_0000_2222;
    req_data[2] = 64'h0000_0000_0000_3333;
    req_data[3] = 64'h0000_0000_0000_4444;
    for (int i = 0; i < 4; i++) req_shift[i] = 6'd4;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    set_all(6'd0, 64'd0);
    #12;
    chk("rst_ready", {60'd0, ready1}, 64'd0);
    chk("rst_valid", {63'd0, rv1}, 64'd0);
    chk("rst_id", {62'd0, rid1}, 64'd0);
    chk("rst_data", rd1, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op, requester 0
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_shift[0] = 6'd4;
    #2;
    chk("s1_ready", {60'd0, ready1}, 64'h1);
    step();
    req_valid = 4'b0000;
    #2;
    chk("s1_lat_t1", {63'd0, rv1}, 64'd0);
    step();
    #2;
    chk("s1_valid", {63'd0, rv1}, 64'd1);
    chk("s1_id", {62'd0, rid1}, 64'd0);
    chk("s1_data", rd1, 64'hFFFF_FFFF_FFFF_FFF0);
    step();
    #2;
    chk("s1_drain", {63'd0, rv1}, 64'd0);

    // Full-rate round robin, shifts 0..63
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 64; k++) begin
      set_all(6'(k), 64'd1);
      exp_oh = 4'b0001 << (k % 4);
      #2;
      chk("s2_grant", {60'd0, ready1}, {60'd0, exp_oh});
      if (k >= 2) begin
        chk("s2_valid", {63'd0, rv1}, 64'd1);
        chk("s2_id", {62'd0, rid1}, 64'((k - 2) % 4));
        chk("s2_data", rd1, 64'd1 << (k - 2));
      end
      step();
    end
    req_valid = 4'b0000;
    #2;
    chk("s2_id62", {62'd0, rid1}, 64'd2);
    chk("s2_data62", rd1, 64'h4000_0000_0000_0000);
    step();
    #2;
    chk("s2_id63", {62'd0, rid1}, 64'd3);
    chk("s2_data63", rd1, 64'h8000_0000_0000_0000);
    step();
    #2;
    chk("s2_empty", {63'd0, rv1}, 64'd0);

    // Backpressure: credit limit then pop-and-issue
    do_reset();
    rsp_ready = 1'b0;
    set_ramp();
    req_valid = 4'b1111;
    #2;
    chk("s3_g0", {60'd0, ready1}, 64'h1);
    step();
    #2;
    chk("s3_g1", {60'd0, ready1}, 64'h2);
    step();
    #2;
    chk("s3_stall_a", {60'd0, ready1}, 64'h0);
    chk("s3_head_a", rd1, 64'h0000_0000_0001_1110);
    step();
    #2;
    chk("s3_stall_b", {60'd0, ready1}, 64'h0);
    chk("s3_hold_id", {62'd0, rid1}, 64'd0);
    chk("s3_hold_data", rd1, 64'h0000_0000_0001_1110);
    step();
    rsp_ready = 1'b1;
    #2;
    chk("s3_popiss", {60'd0, ready1}, 64'h4);
    chk("s3_id0", {62'd0, rid1}, 64'd0);
    step();
    #2;
    chk("s3_g3", {60'd0, ready1}, 64'h8);
    chk("s3_id1", {62'd0, rid1}, 64'd1);
    chk("s3_d1", rd1, 64'h0000_0000_0002_2220);
    step();
    req_valid = 4'b0000;
    #2;
    chk("s3_id2", {62'd0, rid1}, 64'd2);
    chk("s3_d2", rd1, 64'h0000_0000_0003_3330);
    step();
    #2;
    chk("s3_id3", {62'd0, rid1}, 64'd3);
    chk("s3_d3", rd1, 64'h0000_0000_0004_4440);
    step();
    #2;
    chk("s3_empty", {63'd0, rv1}, 64'd0);

    // Sparse requesters 1 and 3, valid dropped while waiting
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #2;
    chk("s4_a", {60'd0, ready1}, 64'h2);
    step();
    req_valid = 4'b1010;
    #2;
    chk("s4_b_ptr2", {60'd0, ready1}, 64'h8);
    step();
    #2;
    chk("s4_c_wrap", {60'd0, ready1}, 64'h2);
    chk("s4_c_id", {62'd0, rid1}, 64'd1);
    step();
    #2;
    chk("s4_d", {60'd0, ready1}, 64'h8);
    chk("s4_d_id", {62'd0, rid1}, 64'd3);
    chk("s4_d_data", rd1, 64'h0000_0000_0004_4440);
    step();
    req_valid = 4'b0000;
    #2;
    chk("s4_e_drop", {60'd0, ready1}, 64'h0);
    chk("s4_e_id", {62'd0, rid1}, 64'd1);
    step();
    req_valid = 4'b1000;
    #2;
    chk("s4_f", {60'd0, ready1}, 64'h8);
    chk("s4_f_id", {62'd0, rid1}, 64'd3);
    step();
    req_valid = 4'b0000;
    #2;
    chk("s4_g_empty", {63'd0, rv1}, 64'd0);
    step();
    #2;
    chk("s4_h_id", {62'd0, rid1}, 64'd3);

    // Reset with two results queued
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    step();
    step();
    step();
    #2;
    chk("s5_queued", {63'd0, rv1}, 64'd1);
    rst = 1'b1;
    #1;
    chk("s5_rst_ready", {60'd0, ready1}, 64'h0);
    chk("s5_rst_valid", {63'd0, rv1}, 64'd0);
    chk("s5_rst_id", {62'd0, rid1}, 64'd0);
    chk("s5_rst_data", rd1, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    #2;
    chk("s5_first", {60'd0, ready1}, 64'h1);
    step();
    req_valid = 4'b0000;
    #2;
    chk("s5_nostale", {63'd0, rv1}, 64'd0);
    step();
    #2;
    chk("s5_valid", {63'd0, rv1}, 64'd1);
    chk("s5_id", {62'd0, rid1}, 64'd0);
    chk("s5_data", rd1, 64'h0000_0000_0001_1110);
    step();
    #2;
    chk("s5_empty", {63'd0, rv1}, 64'd0);

    // OUT_REG=0 instance: single op
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_shift[0] = 6'd4;
    #2;
    chk("s6_ready", {60'd0, ready0}, 64'h1);
    step();
    req_valid = 4'b0000;
    #2;
    chk("s6_valid", {63'd0, rv0}, 64'd1);
    chk("s6_id", {62'd0, rid0}, 64'd0);
    chk("s6_data", rd0, 64'hFFFF_FFFF_FFFF_FFF0);
    step();
    #2;
    chk("s6_drain", {63'd0, rv0}, 64'd0);

    // OUT_REG=0 instance: full-rate round robin
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 64; k++) begin
      set_all(6'(k), 64'd1);
      exp_oh = 4'b0001 << (k % 4);
      #2;
      chk("s7_grant", {60'd0, ready0}, {60'd0, exp_oh});
      if (k >= 1) begin
        chk("s7_id", {62'd0, rid0}, 64'((k - 1) % 4));
        chk("s7_data", rd0, 64'd1 << (k - 1));
      end
      step();
    end
    req_valid = 4'b0000;
    #2;
    chk("s7_id63", {62'd0, rid0}, 64'd3);
    chk("s7_data63", rd0, 64'h8000_0000_0000_0000);
    step();
    #2;
    chk("s7_empty", {63'd0, rv0}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sll_64b_arb.md
# sll_64b_arb

Round-robin arbiter and sequencer that shares one `sll_64b` left shifter among `N_REQ` requesters. Each requester offers a 64-bit operand and a 6-bit shift amount through a valid/ready handshake. The block issues at most one operation per cycle into the shifter, tags it with the requester index, and returns results through a small credit-protected response FIFO with backpressure. It sits between the packing/alignment clients and the shared shifter datapath.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `OUT_REG`, default 1'b1: passed to `sll_64b`; shifter latency L = `OUT_REG` cycles.
- `FIFO_DEPTH`, default 2: response FIFO entries; also the credit limit, ≥ 1+`OUT_REG`.

Ports:
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in `N_REQ`: request pending per requester.
- `req_ready_o` out `N_REQ`: one-hot grant; transfer when valid & ready.
- `req_shift_i` in `N_REQ`×6: shift amount per requester.
- `req_data_i` in `N_REQ`×64: operand per requester.
- `rsp_valid_o` out 1: FIFO head valid.
- `rsp_ready_i` in 1: consumer accepts head.
- `rsp_id_o` out $clog2(`N_REQ`): requester index of head.
- `rsp_data_o` out 64: `req_data << req_shift`, truncated to 64 bits.

## Operation

- Credit counter `cnt` (0..`FIFO_DEPTH`) = ops in shifter + FIFO occupancy. Next `cnt` = `cnt` + issue − pop, where issue = any valid&ready and pop = `rsp_valid_o` & `rsp_ready_i`.
- Issue allowed only when `cnt` < `FIFO_DEPTH`, or when `cnt` == `FIFO_DEPTH` and a pop occurs in the same cycle. The FIFO therefore never overflows and no result is ever dropped.
- Arbitration: round-robin pointer `ptr`. Grant goes to the first valid requester at or after `ptr`, searching upward with wrap. After a grant to i, `ptr` ← (i+1) mod `N_REQ`. `ptr` does not change when there is no grant.
- `req_ready_o` is one-hot or zero and is combinational from `req_valid_i`, `ptr` and credit. A requester may drop valid without penalty.
- On issue, the block drives `sll_64b` as follows: `init_i`=1 for that cycle only, `shift_i`/`data_i` from the granted requester, and the tag (index) enters an L-deep tag pipe. When the shifter is idle, the block holds `init_i`=0 and zeros its inputs.
- FIFO push occurs when shifter `done_o`=1. Push data is {tag pipe output, shifter `data_o`}. Push and pop in the same cycle are legal, including when the FIFO is full-with-pop.
- Shift range: the full 0..63. Shift 0 returns the operand unchanged.

## Timing

- Reset values: `req_ready_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_data_o`=0, `ptr`=0, `cnt`=0, FIFO empty, tag pipe cleared. The shifter reset is driven by ~`rst_i`.
- Latency: an issue at cycle t makes the result visible on `rsp_*` at t+1+L at the earliest (t+2 with `OUT_REG`=1, t+1 with `OUT_REG`=0).
- Sustained throughput is 1 op/cycle when `rsp_ready_i`=1 and `FIFO_DEPTH` ≥ 1+L. Otherwise the block stalls via `req_ready_o`=0.
- `rsp_*` holds stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
- Results return in issue order.
- Reset mid-operation: in-flight and queued results are discarded. The first cycle after reset release may grant.

## Structure

- Package `sll_arb_pkg`: `SHIFT_W`=6, `DATA_W`=64, and a response entry typedef {id, data}.
- Sub-module: one `sll_64b` instance. The FIFO is kept inline as a circular buffer with wrap-around read/write pointers; no separate module.
- Estimated size: ~200 lines of RTL.

## Test plan

- Reset, then requester 0 sends data=64'hFFFF_FFFF_FFFF_FFFF with shift=4 → `rsp_valid_o` at t+2, id=0, data=64'hFFFF_FFFF_FFFF_FFF0 (`OUT_REG`=1).
- All 4 requesters valid continuously with `rsp_ready_i`=1 → grants 0,1,2,3,0,…, one per cycle. Responses return in the same order; data=1<<shift for shift 0..63 matches the model, including shift=63 → 64'h8000_0000_0000_0000.
- `rsp_ready_i`=0 with all requesters valid → exactly `FIFO_DEPTH` issues, then `req_ready_o`=0. Raising ready yields pop-and-issue in the same cycle, with no loss or duplication.
- Only requesters 1 and 3 valid, `ptr`=2 → grant 3 then 1. Dropping valid mid-wait causes no grant to that requester.
- Assert `rst_i` with 2 results queued → outputs go to reset values immediately. After release, the first new request is granted to requester 0 and no stale response appears.
- Repeat the first two scenarios with `OUT_REG`=0 → latency 1 cycle, identical data.
